// File: rtl/ktc32_bus_responder.sv
// ---------------------------------------------------------------------------
// ktc32_bus_responder
//
// Memory-side responder for the ktc32 core bus. It answers single-cycle
// accesses from a multicycle core. Reads are combinational from the address
// because the core latches rd on the edge that ends its access state. Writes
// commit on the rising clock edge.
//
// Address decode:
//   addr >= MMIO_BASE : peripheral window, offset = addr[15:0]
//   otherwise         : word RAM, index = addr[log2(RAM_WORDS)+1:2]
//                       (the upper bits alias modulo the RAM size)
//
// Peripheral map (offsets into the window):
//   0x00 GPIO            R/W 32-bit output register
//   0x04 CONSOLE_TX      W pushes wd[7:0] into the TX FIFO, reads 0
//   0x08 CONSOLE_STATUS  R {count[15:8], overflow[2], empty[1], full[0]}
//                        W wd[2]=1 clears overflow
//   0x0C CYCLE           R free-running counter, W loads it
//   0x10 TIMER_CMP       R/W compare value
//   0x14 TIMER_CTRL      R {pending[1], enable[0]}
//                        W enable<=wd[0], wd[1]=1 clears pending
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous reset, active low
//   memwrite   in   write strobe, commits at the rising edge
//   addr       in   byte address (bits [1:0] ignored)
//   wd         in   write data
//   rd         out  combinational read data
//   con_valid  out  console FIFO non-empty
//   con_data   out  console FIFO head byte (0 when empty)
//   con_ready  in   console sink takes the head byte when valid & ready
//   timer_irq  out  timer interrupt = pending & enable
//   gpio_out   out  GPIO output register
// ---------------------------------------------------------------------------
module ktc32_bus_responder #(
  parameter int unsigned RAM_WORDS  = 1024,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] addr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        timer_irq,
  output logic [31:0] gpio_out
);

  localparam int unsigned IDX_W  = $clog2(RAM_WORDS);
  localparam int unsigned FPTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = FPTR_W + 1;

  localparam logic [15:0] OFF_GPIO   = 16'h0000;
  localparam logic [15:0] OFF_TX     = 16'h0004;
  localparam logic [15:0] OFF_STATUS = 16'h0008;
  localparam logic [15:0] OFF_CYCLE  = 16'h000C;
  localparam logic [15:0] OFF_CMP    = 16'h0010;
  localparam logic [15:0] OFF_CTRL   = 16'h0014;

  localparam logic [CNT_W-1:0] FIFO_FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Storage (never reset)
  logic [31:0] mem_q  [RAM_WORDS];
  logic [7:0]  fifo_q [FIFO_DEPTH];

  // Control / peripheral state
  logic [31:0]       gpio_q,     gpio_d;
  logic [31:0]       cycle_q,    cycle_d;
  logic [31:0]       cmp_q,      cmp_d;
  logic              enable_q,   enable_d;
  logic              pending_q,  pending_d;
  logic              overflow_q, overflow_d;
  logic [FPTR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [FPTR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;

  // Decode
  logic              is_mmio;
  logic [15:0]       offset;
  logic [IDX_W-1:0]  ram_idx;
  logic              wr_ram, wr_gpio, wr_tx, wr_status, wr_cycle, wr_cmp, wr_ctrl;

  // FIFO handshake
  logic fifo_empty, fifo_full;
  logic pop, push_ok, ovf_set;
  logic timer_match;

  assign is_mmio = (addr >= MMIO_BASE);
  assign offset  = addr[15:0];
  assign ram_idx = addr[IDX_W+1:2];

  assign wr_ram    = memwrite & ~is_mmio;
  assign wr_gpio   = memwrite &  is_mmio & (offset == OFF_GPIO);
  assign wr_tx     = memwrite &  is_mmio & (offset == OFF_TX);
  assign wr_status = memwrite &  is_mmio & (offset == OFF_STATUS);
  assign wr_cycle  = memwrite &  is_mmio & (offset == OFF_CYCLE);
  assign wr_cmp    = memwrite &  is_mmio & (offset == OFF_CMP);
  assign wr_ctrl   = memwrite &  is_mmio & (offset == OFF_CTRL);

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FIFO_FULL_CNT);

  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign pop     = ~fifo_empty & con_ready;
  assign push_ok = wr_tx & (~fifo_full | pop);
  assign ovf_set = wr_tx & ~push_ok;

  // Compare against pre-edge CYCLE and the enable that was in force before
  // any CTRL write landing on this same edge.
  assign timer_match = enable_q & (cycle_q == cmp_q);

  // Outputs
  assign con_valid = ~fifo_empty;
  assign con_data  = fifo_empty ? 8'h00 : fifo_q[rd_ptr_q];
  assign timer_irq = pending_q & enable_q;
  assign gpio_out  = gpio_q;

  // Combinational read mux
  always_comb begin
    rd = 32'h0;
    if (is_mmio) begin
      unique case (offset)
        OFF_GPIO:   rd = gpio_q;
        OFF_STATUS: rd = {16'h0, 8'(count_q), 5'b0, overflow_q, fifo_empty, fifo_full};
        OFF_CYCLE:  rd = cycle_q;
        OFF_CMP:    rd = cmp_q;
        OFF_CTRL:   rd = {30'h0, pending_q, enable_q};
        default:    rd = 32'h0;
      endcase
    end else begin
      rd = mem_q[ram_idx];
    end
  end

  // Next-state logic for peripheral and FIFO control
  always_comb begin
    gpio_d     = wr_gpio  ? wd : gpio_q;
    cmp_d      = wr_cmp   ? wd : cmp_q;
    // A CYCLE write overrides this cycle's increment.
    cycle_d    = wr_cycle ? wd : cycle_q + 32'd1;
    enable_d   = wr_ctrl  ? wd[0] : enable_q;

    // Set beats write-1-clear when both happen in one cycle.
    pending_d = pending_q;
    if (wr_ctrl && wd[1]) pending_d = 1'b0;
    if (timer_match)      pending_d = 1'b1;

    overflow_d = overflow_q;
    if (wr_status && wd[2]) overflow_d = 1'b0;
    if (ovf_set)            overflow_d = 1'b1;

    wr_ptr_d = push_ok ? wr_ptr_q + FPTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + FPTR_W'(1) : rd_ptr_q;

    count_d = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers: async active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q     <= 32'h0;
      cycle_q    <= 32'h0;
      cmp_q      <= 32'h0;
      enable_q   <= 1'b0;
      pending_q  <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      gpio_q     <= gpio_d;
      cycle_q    <= cycle_d;
      cmp_q      <= cmp_d;
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Data storage: no reset. Clearing the FIFO pointers is enough to discard
  // queued bytes, and RAM contents survive reset by design.
  always_ff @(posedge clk) begin
    if (wr_ram) begin
      mem_q[ram_idx] <= wd;
    end
    if (push_ok) begin
      fifo_q[wr_ptr_q] <= wd[7:0];
    end
  end

endmodule

// File: tb/tb_ktc32_bus_responder.sv
module tb_ktc32_bus_responder;

  localparam logic [31:0] GPIO   = 32'hFFFF_0000;
  localparam logic [31:0] TX     = 32'hFFFF_0004;
  localparam logic [31:0] STATUS = 32'hFFFF_0008;
  localparam logic [31:0] CYCLE  = 32'hFFFF_000C;
  localparam logic [31:0] CMP    = 32'hFFFF_0010;
  localparam logic [31:0] CTRL   = 32'hFFFF_0014;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wd = 32'h0;
  logic [31:0] rd;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready = 1'b0;
  logic        timer_irq;
  logic [31:0] gpio_out;

  int checks = 0;
  int errors = 0;

  ktc32_bus_responder dut (
    .clk       (clk),
    .reset     (reset),
    .memwrite  (memwrite),
    .addr      (addr),
    .wd        (wd),
    .rd        (rd),
    .con_valid (con_valid),
    .con_data  (con_data),
    .con_ready (con_ready),
    .timer_irq (timer_irq),
    .gpio_out  (gpio_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    string       name;
    logic [31:0] wa;
    logic [31:0] wdat;
    logic [31:0] ra;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Single-cycle write; returns #1 after the committing edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memwrite = 1'b1;
    addr = a;
    wd = d;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp);
    memwrite = 1'b0;
    addr = a;
    #1;
    check(name, rd, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] drain_exp [8];

  initial begin
    // ---------------- reset ----------------
    repeat (3) @(posedge clk);
    #1;
    check("rst_con_valid", 32'(con_valid), 32'h0);
    check("rst_gpio", gpio_out, 32'h0);
    reset = 1'b1;
    #1;
    check("rst_con_data", 32'(con_data), 32'h0);
    check("rst_irq", 32'(timer_irq), 32'h0);
    rd_chk("rst_status", STATUS, 32'h0000_0002);
    rd_chk("rst_ctrl", CTRL, 32'h0);
    rd_chk("rst_cmp", CMP, 32'h0);

    // ---------------- table-driven register/RAM vectors ----------------
    vecs.push_back('{"ram_rw",       32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0010, 32'hDEAD_BEEF});
    vecs.push_back('{"ram_alias",    32'h0000_0014, 32'h1234_5678, 32'h0000_1010, 32'hDEAD_BEEF});
    vecs.push_back('{"ram_alias_w",  32'h0000_2014, 32'hCAFE_F00D, 32'h0000_0014, 32'hCAFE_F00D});
    vecs.push_back('{"ram_byteoff",  32'h0000_0000, 32'h1111_1111, 32'h0000_0017, 32'hCAFE_F00D});
    vecs.push_back('{"gpio_rw",      GPIO,          32'hA5A5_0F0F, GPIO,          32'hA5A5_0F0F});
    vecs.push_back('{"cmp_rw",       CMP,           32'h0000_0ABC, CMP,           32'h0000_0ABC});
    vecs.push_back('{"unmapped",     32'hFFFF_0020, 32'hFFFF_FFFF, 32'hFFFF_0020, 32'h0});
    vecs.push_back('{"tx_reads0",    32'h0000_0040, 32'h0000_0001, TX,            32'h0});
    vecs.push_back('{"mmio_not_ram", GPIO,          32'h0000_0077, 32'h0000_0000, 32'h1111_1111});
    vecs.push_back('{"below_base",   32'hFFFE_FFFC, 32'h0BAD_F00D, 32'h0000_0FFC, 32'h0BAD_F00D});
    foreach (vecs[i]) begin
      wr(vecs[i].wa, vecs[i].wdat);
      rd_chk(vecs[i].name, vecs[i].ra, vecs[i].exp);
    end
    check("gpio_out_pin", gpio_out, 32'h0000_0077);
    wr(CMP, 32'h0);

    // ---------------- console push / drain ----------------
    con_ready = 1'b0;
    memwrite = 1'b1; addr = TX; wd = 32'h41;
    #1;
    check("no_bypass", 32'(con_valid), 32'h0);
    tick();
    memwrite = 1'b0;
    check("valid_after_push", 32'(con_valid), 32'h1);
    check("head_A", 32'(con_data), 32'h41);
    wr(TX, 32'h42);
    rd_chk("status_cnt2", STATUS, 32'h0000_0200);
    con_ready = 1'b1;
    #1;
    check("drain_A", 32'(con_data), 32'h41);
    tick();
    check("drain_B", 32'(con_data), 32'h42);
    tick();
    con_ready = 1'b0;
    check("drained_valid", 32'(con_valid), 32'h0);
    rd_chk("status_empty", STATUS, 32'h0000_0002);

    // ---------------- overflow ----------------
    for (int i = 0; i < 9; i++) wr(TX, 32'(8'h10 + i));
    rd_chk("status_ovf", STATUS, 32'h0000_0805);
    rd_chk("status_read_noside", STATUS, 32'h0000_0805);
    wr(STATUS, 32'h4);
    rd_chk("status_ovf_clr", STATUS, 32'h0000_0801);

    // ---------------- full + simultaneous push/pop ----------------
    memwrite = 1'b1; addr = TX; wd = 32'h5A; con_ready = 1'b1;
    tick();
    memwrite = 1'b0; con_ready = 1'b0;
    rd_chk("status_pushpop", STATUS, 32'h0000_0801);
    for (int i = 0; i < 7; i++) drain_exp[i] = 8'h11 + 8'(i);
    drain_exp[7] = 8'h5A;
    con_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      check($sformatf("drain_%0d", i), 32'(con_data), 32'(drain_exp[i]));
      tick();
    end
    check("drain_done_valid", 32'(con_valid), 32'h0);
    check("drain_done_data", 32'(con_data), 32'h0);
    con_ready = 1'b0;
    rd_chk("status_final_empty", STATUS, 32'h0000_0002);

    // ---------------- timer ----------------
    wr(CMP, 32'd105);
    wr(CYCLE, 32'd100);
    rd_chk("cycle_load", CYCLE, 32'd100);
    wr(CTRL, 32'h1);
    check("irq_before", 32'(timer_irq), 32'h0);
    repeat (4) tick();
    rd_chk("cycle_105", CYCLE, 32'd105);
    check("irq_at_105", 32'(timer_irq), 32'h0);
    tick();
    check("irq_fired", 32'(timer_irq), 32'h1);
    rd_chk("ctrl_pend_en", CTRL, 32'h3);
    wr(CTRL, 32'h3);
    check("irq_cleared", 32'(timer_irq), 32'h0);
    rd_chk("ctrl_after_clr", CTRL, 32'h1);

    wr(CMP, 32'd201);
    wr(CYCLE, 32'd200);
    tick();
    check("irq_pre_201", 32'(timer_irq), 32'h0);
    tick();
    check("irq_201", 32'(timer_irq), 32'h1);
    wr(CTRL, 32'h0);
    check("irq_masked", 32'(timer_irq), 32'h0);
    rd_chk("pending_kept", CTRL, 32'h2);

    // Match on the same edge that enables: old enable (0) applies.
    wr(CTRL, 32'h2);
    rd_chk("ctrl_all_clear", CTRL, 32'h0);
    wr(CMP, 32'd300);
    wr(CYCLE, 32'd300);
    wr(CTRL, 32'h1);
    check("old_enable_irq", 32'(timer_irq), 32'h0);
    tick();
    rd_chk("old_enable_ctrl", CTRL, 32'h1);

    // Set and write-1-clear on the same edge: set wins.
    wr(CMP, 32'd400);
    wr(CYCLE, 32'd399);
    tick();
    wr(CTRL, 32'h3);
    rd_chk("set_wins_ctrl", CTRL, 32'h3);
    check("set_wins_irq", 32'(timer_irq), 32'h1);

    // ---------------- async reset mid-drain ----------------
    wr(GPIO, 32'h0000_1234);
    for (int i = 0; i < 3; i++) wr(TX, 32'(8'h61 + i));
    rd_chk("status_cnt3", STATUS, 32'h0000_0300);
    check("gpio_pre_rst", gpio_out, 32'h0000_1234);
    con_ready = 1'b1;
    #1;
    check("mid_drain_head", 32'(con_data), 32'h61);
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("arst_con_valid", 32'(con_valid), 32'h0);
    check("arst_con_data", 32'(con_data), 32'h0);
    check("arst_gpio", gpio_out, 32'h0);
    check("arst_irq", 32'(timer_irq), 32'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    con_ready = 1'b0;
    rd_chk("arst_cycle0", CYCLE, 32'h0);
    rd_chk("arst_status", STATUS, 32'h0000_0002);
    rd_chk("arst_ctrl", CTRL, 32'h0);
    tick();
    rd_chk("arst_cycle1", CYCLE, 32'h1);
    rd_chk("ram_survives", 32'h0000_0010, 32'hDEAD_BEEF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ktc32_bus_responder.md
Name: ktc32_bus_responder

Overview:
Memory-side responder for the ktc32 core bus (memwrite/addr/wd out of the core, rd into the core).
- Holds a word RAM.
- Holds memory-mapped peripherals: GPIO output register, console TX byte FIFO with valid/ready drain port, free-running cycle counter, compare timer with interrupt.
- The multicycle core latches rd at the edge that ends its access state, so reads are combinational from addr and writes commit on the clock edge.

Parameters:
RAM_WORDS, 1024, RAM depth in 32-bit words; power of two.
FIFO_DEPTH, 8, console TX FIFO depth in bytes; power of two, >= 2.
MMIO_BASE, 32'hFFFF_0000, base address of the peripheral window (64 KiB window).

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
memwrite  input  1  write strobe from core; commits at rising edge
addr  input  32  byte address from core; addr[1:0] ignored
wd  input  32  write data from core
rd  output  32  read data; combinational from addr and current register/RAM state
con_valid  output  1  console FIFO non-empty
con_data  output  8  console FIFO head byte; valid when con_valid=1
con_ready  input  1  console sink accepts head byte when con_valid & con_ready
timer_irq  output  1  timer interrupt = pending & enable
gpio_out  output  32  GPIO output register

Behaviour:
- Reset (reset=0, async): GPIO=0, FIFO empty, overflow flag=0, CYCLE=0, TIMER_CMP=0, enable=0, pending=0.
  - Resulting outputs: con_valid=0, con_data=0, timer_irq=0, gpio_out=0.
  - RAM contents are not reset.
  - Reset mid-operation discards all FIFO contents immediately.
- Decode:
  - addr >= MMIO_BASE selects MMIO, offset = addr[15:0].
  - Otherwise RAM, index = addr[log2(RAM_WORDS)+1:2]. Higher bits are ignored, so addresses alias modulo RAM size.
- RAM: rd = mem[index] combinationally. If memwrite, mem[index] <= wd at the edge; the new value is visible to rd after that edge.
- MMIO map (offsets):
  - 0x00 GPIO: R/W, 32 bits.
  - 0x04 CONSOLE_TX: W pushes wd[7:0]; reads 0.
  - 0x08 CONSOLE_STATUS: R returns {count in [15:8], overflow [2], empty [1], full [0]}. W with wd[2]=1 clears overflow.
  - 0x0C CYCLE: R returns counter; W loads wd.
  - 0x10 TIMER_CMP: R/W.
  - 0x14 TIMER_CTRL: R returns {pending [1], enable [0]}. W: enable<=wd[0]; wd[1]=1 clears pending.
  - Any other offset reads 0; writes there are ignored.
- FIFO:
  - Push occurs on an MMIO write to CONSOLE_TX.
  - Push is accepted if not full, or if a pop occurs in the same cycle (count unchanged in that case).
  - A push that is not accepted drops the byte and sets the sticky overflow flag. If overflow is set and cleared in the same cycle, set wins.
  - Pop occurs when con_valid & con_ready.
  - No bypass: a push into an empty FIFO raises con_valid at the next edge.
  - con_data shows the head byte, and 0 when empty.
  - Pointers wrap modulo FIFO_DEPTH; count ranges 0..FIFO_DEPTH.
- CYCLE: +1 every cycle, wraps 2^32-1 -> 0. A write to CYCLE has priority over the increment in that cycle; the next cycle increments from wd.
- Timer:
  - When enable=1 and CYCLE == TIMER_CMP (pre-edge values), pending <= 1 at the edge.
  - A set and a write-1-clear of pending in the same cycle: set wins.
  - pending stays set while enable=0, but timer_irq is masked (timer_irq = pending & enable).
  - A compare match on the cycle CTRL is written uses the old enable.
- No wait states: every access completes in one cycle. memwrite=0 causes no side effects, including reads of TX and STATUS.

Test Plan:
1. RAM write/read: write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> rd=0xDEADBEEF. Read 0x1010 (aliases with RAM_WORDS=1024) -> 0xDEADBEEF.
2. Console:
   - With con_ready=0, push 'A','B' -> con_valid=1 one cycle after the first push, con_data=0x41, STATUS count=2.
   - Raise con_ready -> 0x41 then 0x42 drained; STATUS reads empty=1.
3. Overflow: with con_ready=0, push 9 bytes -> full=1, overflow=1, 9th byte absent on drain. Write STATUS wd=4 -> overflow=0.
4. Full with simultaneous push and pop: full FIFO, con_ready=1, push 0x5A in the same cycle -> count stays 8, no overflow, 0x5A appears last.
5. Timer:
   - Write CYCLE=100, TIMER_CMP=105, CTRL=1 -> timer_irq=1 after the edge where CYCLE=105.
   - Write CTRL=3 -> pending cleared, timer_irq=0.
   - Write CTRL=0 while pending -> timer_irq=0, pending bit still reads 1.
6. Async reset mid-drain: assert reset=0 between edges with FIFO count=3 and gpio_out=0x1234 -> immediately con_valid=0, gpio_out=0, timer_irq=0; CYCLE reads 0 after release.
